// File: rtl/rot_cmd_queue.sv
// -----------------------------------------------------------------------------
// rot_cmd_queue
//
// Purpose:
//   Queues rotate commands {word, amount, direction} in a small FIFO. The FIFO
//   head is presented to an external combinational 32-bit rotator. The
//   rotator's answer is captured into a single output register that follows a
//   valid/ready handshake. The output register is refilled in the same edge it
//   is drained, so a continuous stream produces one result per cycle.
//
// Parameters:
//   DEPTH       command FIFO depth, power of two in 2..16 (default 4)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream command valid
//   in_ready    high while the FIFO has a free slot (count < DEPTH)
//   in_data     32-bit word to rotate
//   in_amnt     rotate amount 0..31
//   in_dir      1 = rotate left, 0 = rotate right
//   rot_str     FIFO head word, to the rotator data input
//   rot_amnt    FIFO head amount, to the rotator amount input
//   rot_lr      FIFO head direction, to the rotator (1 left, 0 right)
//   rot_result  rotated word returned combinationally by the rotator
//   out_valid   output register holds a valid result
//   out_ready   downstream accepts the result
//   out_data    registered rotated word
//   cmd_count   (only with ROT_CMD_STATS_EN) 16-bit wrapping count of
//               completed output handshakes
//
// Configuration:
//   `define ROT_CMD_STATS_EN to add the cmd_count output and its counter.
// -----------------------------------------------------------------------------
module rot_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amnt,
  input  logic        in_dir,
  output logic [31:0] rot_str,
  output logic [4:0]  rot_amnt,
  output logic        rot_lr,
  input  logic [31:0] rot_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef ROT_CMD_STATS_EN
  ,
  output logic [15:0] cmd_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 32 + 5 + 1;  // one stored command: {data, amnt, dir}

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EW-1:0] cmd_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  state_t        state_q,  state_d;
  logic [31:0]   out_data_q, out_data_d;

  logic          push;
  logic          load;
  logic [EW-1:0] head;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // in_ready looks only at the registered count, so a full FIFO never accepts
  // even when the head is being popped on the same edge.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;

  // The output register is refilled whenever it is empty or being drained.
  // Using count_q (not count_d) keeps a word written this edge from being
  // popped on the same edge.
  assign load = (count_q != '0) && ((state_q == IDLE) || out_ready);

  // ---------------------------------------------------------------------------
  // FIFO head, driven straight to the rotator. The head only changes when the
  // read pointer moves or the head slot is written, so it is stable otherwise.
  // ---------------------------------------------------------------------------
  assign head     = cmd_mem[rd_ptr_q];
  assign rot_str  = head[EW-1 -: 32];
  assign rot_amnt = head[5:1];
  assign rot_lr   = head[0];

  // ---------------------------------------------------------------------------
  // Command storage. No reset needed: the pointers and count define which
  // slots are meaningful. Writes are suppressed during reset so a command
  // presented in the reset cycle leaves no trace.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      cmd_mem[wr_ptr_q] <= {in_data, in_amnt, in_dir};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for pointers, occupancy and the output stage
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;  // power-of-two depth wraps naturally
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, load})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;  // idle, or push and pop cancel
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          out_data_d = rot_result;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (load) begin
          // Drain and refill on the same edge.
          out_data_d = rot_result;
          state_d    = HOLD;
        end else if (out_ready) begin
          // Drained with nothing queued; the last word is simply retained.
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers: pointers, count, output FSM and its registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      out_data_q <= 32'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;

`ifdef ROT_CMD_STATS_EN
  // ---------------------------------------------------------------------------
  // Completed-handshake counter, wraps from 16'hFFFF to 16'h0000.
  // ---------------------------------------------------------------------------
  logic [15:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (out_valid && out_ready) begin
      cmd_count_d = cmd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_count_q <= 16'h0;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd_count = cmd_count_q;
`endif

endmodule

// File: tb/tb_rot_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_rot_cmd_queue
//
// Directed bench for rot_cmd_queue (DEPTH = 4). A behavioural rotator drives
// rot_result from rot_str/rot_amnt/rot_lr. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Build with +define+ROT_CMD_STATS_EN to include the cmd_count checks.
// -----------------------------------------------------------------------------
module tb_rot_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amnt;
  logic        in_dir;
  logic [31:0] rot_str;
  logic [4:0]  rot_amnt;
  logic        rot_lr;
  logic [31:0] rot_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef ROT_CMD_STATS_EN
  logic [15:0] cmd_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rot_cmd_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amnt    (in_amnt),
    .in_dir     (in_dir),
    .rot_str    (rot_str),
    .rot_amnt   (rot_amnt),
    .rot_lr     (rot_lr),
    .rot_result (rot_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef ROT_CMD_STATS_EN
    ,
    .cmd_count  (cmd_count)
`endif
  );

  // Behavioural 32-bit rotator standing in for the external block.
  function automatic logic [31:0] rotate(input logic [31:0] x, input logic [4:0] a,
                                         input logic left);
    logic [63:0] t;
    if (left) begin
      t = {x, x} << a;
      return t[63:32];
    end else begin
      t = {x, x} >> a;
      return t[31:0];
    end
  endfunction

  always_comb rot_result = rotate(rot_str, rot_amnt, rot_lr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic dir);
    in_valid = v;
    in_data  = d;
    in_amnt  = a;
    in_dir   = dir;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Watchdog: the sequence is linear, this only guards against a stuck sim.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // ---------------- reset state ----------------
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'h0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
`ifdef ROT_CMD_STATS_EN
    check("rst_cmd_count", {16'b0, cmd_count}, 32'd0);
`endif

    // ---------------- A: rotate-left, latency ----------------
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0001, 5'd1, 1'b1);
    cyc();                                   // accepted
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("A_valid_n",   {31'b0, out_valid}, 32'd0);
    check("A_rot_str",   rot_str,            32'h8000_0001);
    check("A_rot_amnt",  {27'b0, rot_amnt},  32'd1);
    check("A_rot_lr",    {31'b0, rot_lr},    32'd1);
    cyc();                                   // loaded
    check("A_valid_n1",  {31'b0, out_valid}, 32'd1);
    check("A_data",      out_data,           32'h0000_0003);
    cyc();                                   // drained
    check("A_idle",      {31'b0, out_valid}, 32'd0);
    check("A_retained",  out_data,           32'h0000_0003);

    // ---------------- B: rotate-right and amount 0 ----------------
    drive(1'b1, 32'h0000_000F, 5'd4, 1'b0);
    cyc();
    drive(1'b1, 32'h1234_5678, 5'd0, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("B_valid0",    {31'b0, out_valid}, 32'd1);
    check("B_data0",     out_data,           32'hF000_0000);
    cyc();
    check("B_valid1",    {31'b0, out_valid}, 32'd1);
    check("B_data1",     out_data,           32'h1234_5678);
    cyc();
    check("B_idle",      {31'b0, out_valid}, 32'd0);

    // ---------------- C: fill with out_ready low, then drain ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0001, 5'd4,  1'b1); cyc();
    drive(1'b1, 32'h0000_0010, 5'd4,  1'b0); cyc();
    drive(1'b1, 32'hA5A5_A5A5, 5'd1,  1'b1); cyc();
    drive(1'b1, 32'h0000_0001, 5'd31, 1'b0); cyc();
    check("C_ready_4th", {31'b0, in_ready},  32'd1);
    drive(1'b1, 32'hDEAD_BEEF, 5'd16, 1'b1); cyc();
    check("C_full",      {31'b0, in_ready},  32'd0);
    check("C_hold_v",    {31'b0, out_valid}, 32'd1);
    check("C_hold_d",    out_data,           32'h0000_0010);
    // Offer a sixth command while full: must be refused, output untouched.
    drive(1'b1, 32'hFFFF_FFFF, 5'd3, 1'b1); cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("C_still_full", {31'b0, in_ready}, 32'd0);
    check("C_stall_d",    out_data,          32'h0000_0010);
    out_ready = 1'b1;
    cyc();
    check("C_r1_v",      {31'b0, out_valid}, 32'd1);
    check("C_r1_d",      out_data,           32'h0000_0001);
    check("C_ready_back", {31'b0, in_ready}, 32'd1);
    cyc();
    check("C_r2_d",      out_data,           32'h4B4B_4B4B);
    cyc();
    check("C_r3_d",      out_data,           32'h0000_0002);
    cyc();
    check("C_r4_v",      {31'b0, out_valid}, 32'd1);
    check("C_r4_d",      out_data,           32'hBEEF_DEAD);
    cyc();
    check("C_empty",     {31'b0, out_valid}, 32'd0);

    // ---------------- D: 8-command back-to-back stream ----------------
    for (int k = 0; k < 10; k++) begin
      logic [31:0] exp_d;
      if (k < 8) drive(1'b1, 32'h8000_0000, 5'(k), 1'b0);
      else       drive(1'b0, 32'h0, 5'd0, 1'b0);
      cyc();
      check("D_ready", {31'b0, in_ready}, 32'd1);
      if (k >= 1 && k <= 8) begin
        exp_d = 32'h8000_0000 >> (k - 1);
        check("D_valid", {31'b0, out_valid}, 32'd1);
        check("D_data",  out_data,           exp_d);
      end else begin
        check("D_bubble", {31'b0, out_valid}, 32'd0);
      end
    end

    // ---------------- E: reset mid-operation ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 5'd0, 1'b0); cyc();
    drive(1'b1, 32'h2222_2222, 5'd0, 1'b0); cyc();
    drive(1'b1, 32'h3333_3333, 5'd0, 1'b0); cyc();
    drive(1'b1, 32'h4444_4444, 5'd0, 1'b0); cyc();
    check("E_pre_v",     {31'b0, out_valid}, 32'd1);
    check("E_pre_d",     out_data,           32'h1111_1111);
    // Handshakes offered during the reset cycle must be ignored.
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h5555_5555, 5'd0, 1'b0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("E_rst_v",     {31'b0, out_valid}, 32'd0);
    check("E_rst_d",     out_data,           32'h0);
    check("E_rst_rdy",   {31'b0, in_ready},  32'd1);
`ifdef ROT_CMD_STATS_EN
    check("E_rst_cnt",   {16'b0, cmd_count}, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("E_no_stale", {31'b0, out_valid}, 32'd0);
    end
    drive(1'b1, 32'h0000_FFFF, 5'd8, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("E_new_lat",   {31'b0, out_valid}, 32'd0);
    cyc();
    check("E_new_v",     {31'b0, out_valid}, 32'd1);
    check("E_new_d",     out_data,           32'h00FF_FF00);
    cyc();
    check("E_new_done",  {31'b0, out_valid}, 32'd0);
`ifdef ROT_CMD_STATS_EN
    check("E_cnt1",      {16'b0, cmd_count}, 32'd1);
`endif

    // ---------------- F: more handshakes, then stall ----------------
    drive(1'b1, 32'hCAFE_F00D, 5'd0, 1'b1); cyc();
    drive(1'b1, 32'h0123_4567, 5'd0, 1'b0); cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("F_d0",        out_data,           32'hCAFE_F00D);
    cyc();
    check("F_d1",        out_data,           32'h0123_4567);
    cyc();
    check("F_idle",      {31'b0, out_valid}, 32'd0);
`ifdef ROT_CMD_STATS_EN
    check("F_cnt3",      {16'b0, cmd_count}, 32'd3);
`endif
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0005, 5'd0, 1'b0); cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    cyc();
    check("F_stall_v",   {31'b0, out_valid}, 32'd1);
    check("F_stall_d",   out_data,           32'h0000_0005);
    cyc();
    cyc();
    check("F_stall_v2",  {31'b0, out_valid}, 32'd1);
`ifdef ROT_CMD_STATS_EN
    check("F_cnt_hold",  {16'b0, cmd_count}, 32'd3);
`endif
    out_ready = 1'b1;
    cyc();
    check("F_release",   {31'b0, out_valid}, 32'd0);
`ifdef ROT_CMD_STATS_EN
    check("F_cnt4",      {16'b0, cmd_count}, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rot_cmd_queue.md
ROT_CMD_QUEUE -- requirements
Module: rot_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  command accepted on edge where in_valid && in_ready.
REQ-006 in_data  input  32  word to rotate.
REQ-007 in_amnt  input  5  rotate amount, 0..31.
REQ-008 in_dir  input  1  direction, 1 = left, 0 = right.
REQ-009 rot_str  output  32  FIFO head word to the rotator's 32-bit data input.
REQ-010 rot_amnt  output  5  FIFO head amount to the rotator's amount input.
REQ-011 rot_lr  output  1  FIFO head direction to the rotator (1 left, 0 right).
REQ-012 rot_result  input  32  combinational rotated word returned by the rotator.
REQ-013 out_valid  output  1  result register holds a valid word.
REQ-014 out_ready  input  1  downstream accepts on edge where out_valid && out_ready.
REQ-015 out_data  output  32  registered rotated word.

Function
REQ-016 Command FIFO SHALL store {in_data, in_amnt, in_dir} in order, DEPTH entries, wrap-around read/write pointers with a separate occupancy count of 0..DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH); no same-cycle bypass when full, even if a pop occurs that edge.
REQ-018 rot_str/rot_amnt/rot_lr SHALL be driven combinationally from the FIFO head; value when empty is don't-care, but held stable while head unchanged.
REQ-019 Output FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-020 Load condition: count > 0 && (state == IDLE || out_ready); on load, out_data <= rot_result, head popped, state -> HOLD.
REQ-021 In HOLD with out_ready=1 and FIFO empty: state -> IDLE, out_data retained.
REQ-022 In HOLD with out_ready=0: out_data and out_valid SHALL stay unchanged (no overwrite).
REQ-023 Latency: command accepted at edge N into an empty queue with IDLE output SHALL show out_valid=1 after edge N+1.
REQ-024 Throughput: with out_ready held 1 and in_valid held 1, one result per cycle sustained.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance; push into empty FIFO SHALL NOT be popped the same edge.
REQ-026 Results SHALL leave in acceptance order; no command dropped or duplicated.
REQ-027 Amount 0 SHALL pass the word unchanged, direction irrelevant.

Reset
REQ-028 On rst=1 at an edge: count=0, both pointers=0, state=IDLE, out_valid=0, out_data=32'h0, in_ready=1 from the following cycle.
REQ-029 Reset mid-operation SHALL discard all queued commands and any held result; handshakes presented in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro ROT_CMD_STATS_EN: when defined, adds output cmd_count (16 bits) counting completed output handshakes, reset to 0, wrapping 16'hFFFF -> 16'h0000.
REQ-031 Without ROT_CMD_STATS_EN, port cmd_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Push 0x80000001, amnt 1, dir 1, out_ready=1 -> out_data 0x00000003, out_valid one cycle after acceptance edge.
REQ-033 Push 0x0000000F, amnt 4, dir 0 -> out_data 0xF0000000; push 0x12345678, amnt 0 -> 0x12345678.
REQ-034 out_ready=0, push DEPTH+1=5 commands -> 5 accepted, in_ready=0 after 5th; release out_ready -> 5 results in order, in_ready high again.
REQ-035 Back-to-back stream of 8 commands with out_ready=1 -> 8 consecutive out_valid cycles, no bubbles after the first.
REQ-036 Assert rst with 3 queued and out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result later emerges.
REQ-037 With ROT_CMD_STATS_EN, complete 3 handshakes -> cmd_count=3; stall out_ready=0 -> cmd_count holds.
